// File: rtl/conv_pkg.sv
// Shared widths and read-side state encoding for the
// pooled-result double buffer.
package conv_pkg;
  localparam int DW    = 9;
  localparam int N_PIX = 9;
  localparam int SW    = 13;
  localparam int IW    = 4;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_e;
endpackage

// File: rtl/pool_result_buffer_if.sv
// Upstream strobe, downstream stream handshake and
// per-frame statistics of the pooled-result buffer.
interface pool_result_buffer_if #(
  parameter int DW = conv_pkg::DW
);
  import conv_pkg::*;

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          clr_ovf;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic [DW-1:0] frame_max;
  logic [IW-1:0] frame_argmax;
  logic [SW-1:0] frame_sum;
  logic          ovf;

  modport master (
    output in_valid, in_data, out_ready, clr_ovf,
    input  out_valid, out_data, out_idx, out_last,
    input  frame_max, frame_argmax, frame_sum, ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready, clr_ovf,
    output out_valid, out_data, out_idx, out_last,
    output frame_max, frame_argmax, frame_sum, ovf
  );
endinterface

// File: rtl/pool_frame_bank.sv
// One frame of pooled words with running max, argmax
// and sum, restarted by the word written at index 0.
module pool_frame_bank
  import conv_pkg::*;
#(
  parameter int DW    = conv_pkg::DW,
  parameter int N_PIX = conv_pkg::N_PIX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [DW-1:0] din,
  input  logic [IW-1:0] rd_idx,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] max_val,
  output logic [IW-1:0] max_idx,
  output logic [SW-1:0] sum_val
);

  logic [DW-1:0] mem [N_PIX];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PIX; i++)
        mem[i] <= '0;
      max_val <= '0;
      max_idx <= '0;
      sum_val <= '0;
    end else if (we) begin
      mem[wr_idx] <= din;
      if (wr_idx == '0) begin
        max_val <= din;
        max_idx <= '0;
        sum_val <= SW'(din);
      end else begin
        sum_val <= sum_val + SW'(din);
        // strict compare keeps the lowest index on ties
        if (din > max_val) begin
          max_val <= din;
          max_idx <= wr_idx;
        end
      end
    end
  end

  assign rdata = mem[rd_idx];

endmodule

// File: rtl/pool_result_buffer.sv
// Ping-pong frame buffer: write side fills one bank while
// the read FSM streams the other with its statistics.
module pool_result_buffer
  import conv_pkg::*;
#(
  parameter int DW    = conv_pkg::DW,
  parameter int N_PIX = conv_pkg::N_PIX
) (
  input logic                 clk,
  input logic                 rst_n,
  pool_result_buffer_if.slave bus
);

  localparam logic [IW-1:0] LAST = IW'(N_PIX - 1);

  rd_state_e     state_q, state_d;
  logic [IW-1:0] wr_cnt, rd_idx;
  logic          w_bank, r_bank;
  logic          dropping, full_q, ovf_q;
  logic [1:0]    full;
  logic          stream, hs, hs_last;
  logic          w_full, start_drop, store;

  logic [DW-1:0] rdata   [2];
  logic [DW-1:0] max_v   [2];
  logic [IW-1:0] max_i   [2];
  logic [SW-1:0] sum_v   [2];

  assign stream  = (state_q == RD_STREAM);
  assign hs      = stream && bus.out_ready;
  assign hs_last = hs && (rd_idx == LAST);

  // a bank freed on this edge may take the next frame
  assign w_full = full[w_bank] &&
                  !(hs_last && (r_bank == w_bank));

  assign start_drop = bus.in_valid && !dropping &&
                      (wr_cnt == '0) && w_full;
  assign store = bus.in_valid && !dropping &&
                 !start_drop;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pool_frame_bank #(
      .DW    (DW),
      .N_PIX (N_PIX)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (store && (w_bank == 1'(b))),
      .wr_idx  (wr_cnt),
      .din     (bus.in_data),
      .rd_idx  (rd_idx),
      .rdata   (rdata[b]),
      .max_val (max_v[b]),
      .max_idx (max_i[b]),
      .sum_val (sum_v[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      w_bank   <= 1'b0;
      r_bank   <= 1'b0;
      dropping <= 1'b0;
      full     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        wr_cnt   <= (wr_cnt == LAST) ? '0
                                     : wr_cnt + IW'(1);
        dropping <= start_drop ||
                    (dropping && (wr_cnt != LAST));
      end
      if (hs_last) begin
        full[r_bank] <= 1'b0;
        r_bank       <= ~r_bank;
      end
      if (store && (wr_cnt == LAST)) begin
        full[w_bank] <= 1'b1;
        w_bank       <= ~w_bank;
      end
      if (start_drop)
        ovf_q <= 1'b1;
      else if (bus.clr_ovf)
        ovf_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:   if (full_q)  state_d = RD_STREAM;
      RD_STREAM: if (hs_last) state_d = RD_IDLE;
      default:                state_d = RD_IDLE;
    endcase
  end

  // full_q adds the second edge of start-up latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RD_IDLE;
      rd_idx  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= hs_last ? 1'b0 : full[r_bank];
      if (hs)
        rd_idx <= hs_last ? '0 : rd_idx + IW'(1);
    end
  end

  assign bus.out_valid    = stream;
  assign bus.out_data     = rdata[r_bank];
  assign bus.out_idx      = rd_idx;
  assign bus.out_last     = (rd_idx == LAST);
  assign bus.frame_max    = max_v[r_bank];
  assign bus.frame_argmax = max_i[r_bank];
  assign bus.frame_sum    = sum_v[r_bank];
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_pool_result_buffer.sv
// Bench for pool_result_buffer: directed frames plus random
// traffic against a frame-queue reference model.
module tb_pool_result_buffer;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pool_result_buffer_if bus ();

  pool_result_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [DW-1:0] qw[$];
  logic [DW-1:0] cur[$];
  logic [DW-1:0] fr[N_PIX];
  int rp = 0;
  int drop_left = 0;
  bit exp_ovf = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    qw.delete();
    cur.delete();
    rp = 0;
    drop_left = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic chk_zero();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_idx", bus.out_idx, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_max", bus.frame_max, 0);
    chk("rst_argmax", bus.frame_argmax, 0);
    chk("rst_sum", bus.frame_sum, 0);
    chk("rst_ovf", bus.ovf, 0);
  endtask

  task automatic check_outputs();
    int mx, am, sm;
    chk("ovf", bus.ovf, exp_ovf);
    if (qw.size() == 0) begin
      chk("valid_no_frame", bus.out_valid, 0);
    end else if (bus.out_valid) begin
      mx = qw[0]; am = 0; sm = 0;
      for (int i = 0; i < N_PIX; i++) begin
        sm += qw[i];
        if (qw[i] > mx) begin
          mx = qw[i];
          am = i;
        end
      end
      chk("out_data", bus.out_data, qw[rp]);
      chk("out_idx", bus.out_idx, rp);
      chk("out_last", bus.out_last, rp == N_PIX - 1);
      chk("frame_max", bus.frame_max, mx);
      chk("frame_argmax", bus.frame_argmax, am);
      chk("frame_sum", bus.frame_sum, sm);
    end
  endtask

  // one clock: check, drive, then advance the model
  task automatic cycle(input bit v, input logic [DW-1:0] d,
                       input bit rdy, input bit clr);
    bit ov;
    bit dropped;
    check_outputs();
    ov = bus.out_valid;
    dropped = 1'b0;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.clr_ovf   = clr;
    if (ov && rdy && qw.size() >= N_PIX) begin
      if (rp == N_PIX - 1) begin
        repeat (N_PIX) void'(qw.pop_front());
        rp = 0;
      end else begin
        rp++;
      end
    end
    if (v) begin
      if (drop_left > 0) begin
        drop_left--;
      end else if (cur.size() == 0 &&
                   qw.size() == 2 * N_PIX) begin
        dropped = 1'b1;
        drop_left = N_PIX - 1;
      end else begin
        cur.push_back(d);
        if (cur.size() == N_PIX) begin
          foreach (cur[i]) qw.push_back(cur[i]);
          cur.delete();
        end
      end
    end
    if (dropped) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_fr(input bit rdy);
    for (int i = 0; i < N_PIX; i++)
      cycle(1'b1, fr[i], rdy, 1'b0);
  endtask

  task automatic wait_valid(input int exp_n);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("latency", n, exp_n);
  endtask

  task automatic drain(input bit toggle);
    int n = 0;
    bit r = 1'b1;
    while (qw.size() != 0 && n < 400) begin
      cycle(1'b0, '0, r, 1'b0);
      if (toggle) r = ~r;
      n++;
    end
    chk("drained", qw.size(), 0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero();
    rst_n = 1'b1;
    @(negedge clk);

    // ascending frame, latency and statistics
    for (int i = 0; i < N_PIX; i++) fr[i] = DW'(i + 1);
    send_fr(1'b1);
    wait_valid(2);
    drain(1'b0);

    // all-max frame: sum width and tie rule
    for (int i = 0; i < N_PIX; i++) fr[i] = DW'(511);
    send_fr(1'b1);
    drain(1'b0);

    // repeated maximum with a stalling consumer
    foreach (fr[i]) fr[i] = '0;
    fr[0] = DW'(5); fr[1] = DW'(9); fr[2] = DW'(9);
    send_fr(1'b1);
    drain(1'b1);

    // three frames into a stalled reader: third dropped
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N_PIX; i++)
        fr[i] = DW'(f * 20 + i);
      send_fr(1'b0);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    drain(1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // free of a bank on the first word of the next frame
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N_PIX; i++)
        fr[i] = DW'(100 + f * 10 + i);
      send_fr(1'b0);
    end
    n = 0;
    while (!bus.out_valid && n < 10) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    n = 0;
    while (!(bus.out_valid && rp == N_PIX - 1) && n < 30) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("coincide_last", bus.out_last, 1);
    cycle(1'b1, DW'(300), 1'b1, 1'b0);
    for (int i = 1; i < N_PIX; i++)
      cycle(1'b1, DW'(300 + i), 1'b0, 1'b0);
    drain(1'b0);

    // reset in the middle of a frame
    for (int i = 0; i < 4; i++)
      cycle(1'b1, DW'(50 + i), 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N_PIX; i++) fr[i] = DW'(200 - i);
    send_fr(1'b1);
    wait_valid(2);
    drain(1'b0);

    // random traffic, gaps, stalls, occasional clears
    for (int c = 0; c < 1500; c++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 1) == 0) ?
          DW'($urandom_range(0, 15)) : DW'($urandom);
      cycle($urandom_range(0, 9) < 7, d,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 49) == 0);
    end
    n = 0;
    while ((cur.size() != 0 || drop_left != 0) && n < 20) begin
      cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
      n++;
    end
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pool_result_buffer.md
POOL_RESULT_BUFFER -- requirements
Module: pool_result_buffer

Interface
REQ-001 Parameter DW, 9, width of each pooled result word.
REQ-002 Parameter N_PIX, 9, result words per frame (3x3 pooled map).
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  upstream pooled-result strobe; no backpressure to upstream.
REQ-006 in_data  in  DW  pooled result, sampled only when in_valid=1.
REQ-007 out_ready  in  1  downstream accept.
REQ-008 clr_ovf  in  1  synchronous clear of the ovf flag.
REQ-009 out_valid  out  1  out_data/out_idx/out_last valid.
REQ-010 out_data  out  DW  buffered result word.
REQ-011 out_idx  out  4  raster index 0..8 of out_data.
REQ-012 out_last  out  1  high with out_idx=8.
REQ-013 frame_max  out  DW  maximum of the frame being streamed.
REQ-014 frame_argmax  out  4  index of frame_max.
REQ-015 frame_sum  out  13  sum of all 9 words of the frame being streamed.
REQ-016 ovf  out  1  sticky: at least one frame dropped.

Function
REQ-017 Two frame banks SHALL exist; the write side fills bank w_bank, the read side drains bank r_bank; each bank has a full flag.
REQ-018 Write counter wr_cnt (0..8) SHALL store in_data at index wr_cnt of w_bank on each in_valid; consecutive in_valid pulses SHALL be treated as one frame regardless of gaps.
REQ-019 Per bank, the running max, argmax and 13-bit sum SHALL update with every stored word; argmax updates only on strictly greater values (lowest index wins ties); 9x511=4599 SHALL not overflow.
REQ-020 On storing the word with wr_cnt=8: that bank's full flag SHALL set, wr_cnt SHALL return to 0, w_bank SHALL toggle.
REQ-021 If in_valid arrives with wr_cnt=0 and w_bank is full, the whole frame (9 words) SHALL be discarded, ovf SHALL set, and no bank state SHALL change.
REQ-022 Read FSM states IDLE and STREAM; IDLE->STREAM when r_bank is full; STREAM->IDLE on handshake (out_valid&out_ready) with out_idx=8.
REQ-023 out_valid SHALL be 1 exactly in STREAM; it SHALL rise two rising edges after the edge that stored the ninth word, given the read side was IDLE.
REQ-024 out_idx SHALL advance by one per handshake only; out_data/out_idx/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 frame_max/frame_argmax/frame_sum SHALL reflect r_bank and hold stable for the whole STREAM period; outside STREAM they are don't-care but SHALL not be X after reset.
REQ-026 On the final handshake the r_bank full flag SHALL clear and r_bank SHALL toggle on the same edge.
REQ-027 If that free and a first word of a new frame targeting the same bank coincide, the free SHALL take priority and the frame SHALL be accepted.
REQ-028 ovf SHALL clear on clr_ovf=1 unless a drop occurs the same cycle (set wins).

Reset
REQ-029 On rst_n=0: out_valid=0, out_data=0, out_idx=0, out_last=0, frame_max=0, frame_argmax=0, frame_sum=0, ovf=0, both full flags=0, wr_cnt=0, w_bank=r_bank=0, FSM=IDLE, drop state cleared.
REQ-030 Reset mid-frame or mid-stream SHALL discard all buffered data; operation resumes with the next in_valid as index 0.

Structure
REQ-031 DW, N_PIX, the 13-bit sum width and the read-FSM state enum SHALL live in shared package conv_pkg.
REQ-032 One sub-module pool_frame_bank (9xDW storage plus running max/argmax/sum, instantiated twice) is natural; the FSM and bank arbitration stay in the top.

Verification
REQ-033 Frame 1..9 with out_ready=1 -> out_data 1..9, out_idx 0..8, out_last on 9, frame_max=9, frame_argmax=8, frame_sum=45, first out_valid 2 edges after ninth input.
REQ-034 Frame all 511 -> frame_sum=4599, frame_argmax=0 (tie rule).
REQ-035 Frame 5,9,9,0,0,0,0,0,0 with out_ready toggling every cycle -> words held while stalled, argmax=1, sum=23.
REQ-036 Three back-to-back frames with out_ready=0 -> first two buffered, third dropped, ovf=1; raising out_ready streams frames 1 then 2 only.
REQ-037 Free of a bank coinciding with the first word of the next frame -> frame accepted, ovf stays 0.
REQ-038 rst_n pulsed after 4 words of a frame -> out_valid=0; next 9 words stream as a fresh frame.
